fifo_rd_ctrl: RTL and testbench

//  Read-side controller of the async FIFO, running in the read clock domain.
//  - Owns the read pointer and converts it to Gray for the write domain.
//  - Takes the write pointer after the 2-flop sync and derives empty,

---
 rtl/fifo_rd_ctrl_if.sv | 43 ++++
 rtl/fifo_rd_ctrl.sv | 95 +++++++++
 tb/tb_fifo_rd_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bundle of the async FIFO: synchronized write pointer and consumer
// handshake in, memory sequencing, Gray read pointer and status out.
interface fifo_rd_ctrl_if #(
  parameter int unsigned ADDR = 4
);

  logic [ADDR:0]   i_wptr_gray_sync;
  logic            i_rd_ready;
  logic            o_rd_valid;
  logic            o_mem_rd_en;
  logic [ADDR-1:0] o_mem_raddr;
  logic [ADDR:0]   o_rptr_gray;
  logic            o_empty;
  logic            o_almost_empty;
  logic [ADDR:0]   o_level;

  // Controller side.
  modport master (
    input  i_wptr_gray_sync,
    input  i_rd_ready,
    output o_rd_valid,
    output o_mem_rd_en,
    output o_mem_raddr,
    output o_rptr_gray,
    output o_empty,
    output o_almost_empty,
    output o_level
  );

  // Environment side: synchronizer, consumer and memory.
  modport slave (
    output i_wptr_gray_sync,
    output i_rd_ready,
    input  o_rd_valid,
    input  o_mem_rd_en,
    input  o_mem_raddr,
    input  o_rptr_gray,
    input  o_empty,
    input  o_almost_empty,
    input  o_level
  );

endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO (read clock domain).
// Owns the read pointer, publishes it in Gray, derives empty / almost-empty /
// level from the synchronized write pointer and sequences a sync-read memory
// so the consumer sees a first-word-fall-through valid/ready stream.
module fifo_rd_ctrl #(
  parameter int unsigned ADDR   = 4,
  parameter int unsigned AE_LVL = 2
) (
  input logic            i_clk,
  input logic            i_rst,
  fifo_rd_ctrl_if.master bus
);

  localparam int unsigned  PW     = ADDR + 1;
  localparam logic [ADDR:0] AeLvl  = PW'(AE_LVL);
  localparam logic [ADDR:0] LvlMax = PW'((2 ** ADDR) + 1);

  logic [ADDR:0] rbin_q, rbin_d;
  logic [ADDR:0] rgray_q, rgray_d;
  logic [ADDR:0] level_q, level_d;
  logic [ADDR:0] wbin;
  logic          rd_valid_q, rd_valid_d;
  logic          empty_q, empty_d;
  logic          almost_empty_q, almost_empty_d;
  logic          fetch;

  // Binary value of a Gray code: XOR of all right shifts of the code.
  function automatic logic [ADDR:0] gray2bin(input logic [ADDR:0] g);
    logic [ADDR:0] b;
    b = g;
    for (int unsigned s = 1; s < PW; s++) begin
      b = b ^ (g >> s);
    end
    return b;
  endfunction

  // Next-state: fetch whenever the output register is free or being drained.
  always_comb begin
    fetch          = ~empty_q & (~rd_valid_q | bus.i_rd_ready);
    rbin_d         = rbin_q + PW'(fetch);
    rgray_d        = rbin_d ^ (rbin_d >> 1);
    rd_valid_d     = fetch | (rd_valid_q & ~bus.i_rd_ready);
    wbin           = gray2bin(bus.i_wptr_gray_sync);
    // Compare against the next pointer so the last fetch sets empty on its own edge.
    empty_d        = (rgray_d == bus.i_wptr_gray_sync);
    // Words still in memory plus the one held in the memory output register.
    level_d        = (wbin - rbin_d) + PW'(rd_valid_d);
    almost_empty_d = (level_d <= AeLvl);
  end

  // State registers; reset drops any word in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rbin_q         <= '0;
      rgray_q        <= '0;
      rd_valid_q     <= 1'b0;
      empty_q        <= 1'b1;
      level_q        <= '0;
      almost_empty_q <= 1'b1;
    end else begin
      rbin_q         <= rbin_d;
      rgray_q        <= rgray_d;
      rd_valid_q     <= rd_valid_d;
      empty_q        <= empty_d;
      level_q        <= level_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  assign bus.o_mem_rd_en    = fetch;
  assign bus.o_mem_raddr    = rbin_q[ADDR-1:0];
  assign bus.o_rptr_gray    = rgray_q;
  assign bus.o_rd_valid     = rd_valid_q;
  assign bus.o_empty        = empty_q;
  assign bus.o_almost_empty = almost_empty_q;
  assign bus.o_level        = level_q;

`ifndef SYNTHESIS
  // The write-side synchronizer relies on single-bit pointer steps.
  a_gray_step : assert property (@(posedge i_clk) disable iff (i_rst)
    $countones(rgray_q ^ rgray_d) <= 1);

  a_no_fetch_empty : assert property (@(posedge i_clk) disable iff (i_rst)
    empty_q |-> !fetch);

  // A stalled word must stay presented until accepted.
  a_stall_hold : assert property (@(posedge i_clk) disable iff (i_rst)
    (rd_valid_q && !bus.i_rd_ready) |=> rd_valid_q);

  // Exceeding this means the write side overran the memory.
  a_level_bound : assert property (@(posedge i_clk) disable iff (i_rst)
    level_q <= LvlMax);
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a small sync-read memory model.
module tb_fifo_rd_ctrl;

  localparam int unsigned ADDR = 4;

  logic       clk;
  logic       rst;
  logic [7:0] mem [16];
  logic [7:0] rdata;
  int         n_chk;
  int         n_pass;

  fifo_rd_ctrl_if #(.ADDR(ADDR)) bus ();

  fifo_rd_ctrl #(
    .ADDR  (ADDR),
    .AE_LVL(2)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sync-read memory: output register holds while rd_en is low.
  always @(posedge clk) begin
    if (bus.o_mem_rd_en) rdata <= mem[bus.o_mem_raddr];
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
  endtask

  function automatic logic [4:0] bin2gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [7:0] dat(input int n);
    return 8'((n * 37 + 11) & 255);
  endfunction

  task automatic do_reset(input logic [4:0] wg, input logic rdy);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.i_wptr_gray_sync = wg;
    bus.i_rd_ready = rdy;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'hA0 + i);
  endtask

  initial begin
    int       wcnt, wseen, fcnt, popcnt, lvl;
    logic     vexp, fexp, eexp;
    logic [4:0] prev_gray;

    n_chk = 0;
    n_pass = 0;
    fill_mem();

    // 1: reset held with a nonzero write pointer, then release.
    rst = 1'b1;
    bus.i_wptr_gray_sync = bin2gray(5'd5);
    bus.i_rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("t1_rst_empty", bus.o_empty, 1);
    check_eq("t1_rst_valid", bus.o_rd_valid, 0);
    check_eq("t1_rst_rgray", bus.o_rptr_gray, 0);
    check_eq("t1_rst_level", bus.o_level, 0);
    check_eq("t1_rst_ae", bus.o_almost_empty, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("t1_empty_clr", bus.o_empty, 0);
    check_eq("t1_level", bus.o_level, 5);
    check_eq("t1_ae", bus.o_almost_empty, 0);
    check_eq("t1_rd_en", bus.o_mem_rd_en, 1);
    check_eq("t1_raddr", bus.o_mem_raddr, 0);

    // 2: single word; ready high while empty is ignored.
    do_reset(5'd0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check_eq("t2_empty0", bus.o_empty, 1);
    check_eq("t2_no_rd_en", bus.o_mem_rd_en, 0);
    bus.i_wptr_gray_sync = bin2gray(5'd1);
    @(posedge clk);
    @(negedge clk);
    check_eq("t2_empty_clr", bus.o_empty, 0);
    check_eq("t2_rd_en", bus.o_mem_rd_en, 1);
    check_eq("t2_raddr", bus.o_mem_raddr, 0);
    check_eq("t2_level1", bus.o_level, 1);
    @(posedge clk);
    @(negedge clk);
    check_eq("t2_valid", bus.o_rd_valid, 1);
    check_eq("t2_data", rdata, 8'hA0);
    check_eq("t2_empty_set", bus.o_empty, 1);
    check_eq("t2_rd_en_off", bus.o_mem_rd_en, 0);
    check_eq("t2_rgray", bus.o_rptr_gray, 1);
    @(posedge clk);
    @(negedge clk);
    check_eq("t2_valid_drop", bus.o_rd_valid, 0);
    check_eq("t2_level0", bus.o_level, 0);

    // 3: full burst of 16 words with ready held high.
    do_reset(5'd0, 1'b1);
    bus.i_wptr_gray_sync = bin2gray(5'd16);
    @(posedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      lvl = (k == 0) ? 16 : 17 - k;
      check_eq($sformatf("t3_rd_en_%0d", k), bus.o_mem_rd_en, 1);
      check_eq($sformatf("t3_raddr_%0d", k), bus.o_mem_raddr, k);
      check_eq($sformatf("t3_level_%0d", k), bus.o_level, lvl);
      check_eq($sformatf("t3_ae_%0d", k), bus.o_almost_empty, lvl <= 2);
      check_eq($sformatf("t3_valid_%0d", k), bus.o_rd_valid, k != 0);
      if (k > 0) check_eq($sformatf("t3_data_%0d", k), rdata, 8'hA0 + k - 1);
      @(posedge clk);
    end
    @(negedge clk);
    check_eq("t3_last_valid", bus.o_rd_valid, 1);
    check_eq("t3_last_data", rdata, 8'hAF);
    check_eq("t3_empty", bus.o_empty, 1);
    check_eq("t3_rd_en_off", bus.o_mem_rd_en, 0);
    check_eq("t3_rgray", bus.o_rptr_gray, 5'h18);
    check_eq("t3_level1", bus.o_level, 1);
    @(posedge clk);
    @(negedge clk);
    check_eq("t3_drained", bus.o_rd_valid, 0);
    check_eq("t3_level0", bus.o_level, 0);

    // 4: stall with 4 words, then drain.
    do_reset(5'd0, 1'b0);
    bus.i_wptr_gray_sync = bin2gray(5'd4);
    @(posedge clk);
    @(negedge clk);
    check_eq("t4_first_rd_en", bus.o_mem_rd_en, 1);
    check_eq("t4_first_raddr", bus.o_mem_raddr, 0);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq($sformatf("t4_stall_valid_%0d", k), bus.o_rd_valid, 1);
      check_eq($sformatf("t4_stall_rd_en_%0d", k), bus.o_mem_rd_en, 0);
      check_eq($sformatf("t4_stall_level_%0d", k), bus.o_level, 4);
      check_eq($sformatf("t4_stall_data_%0d", k), rdata, 8'hA0);
      @(posedge clk);
    end
    #1;
    bus.i_rd_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check_eq($sformatf("t4_rd_en_%0d", k), bus.o_mem_rd_en, 1);
      check_eq($sformatf("t4_raddr_%0d", k), bus.o_mem_raddr, k);
      check_eq($sformatf("t4_data_%0d", k), rdata, 8'hA0 + k - 1);
      check_eq($sformatf("t4_level_%0d", k), bus.o_level, 5 - k);
      @(posedge clk);
    end
    @(negedge clk);
    check_eq("t4_empty", bus.o_empty, 1);
    check_eq("t4_rd_en_off", bus.o_mem_rd_en, 0);
    check_eq("t4_last_data", rdata, 8'hA3);

    // 5: 40-word stream with random write pacing and random ready.
    do_reset(5'd0, 1'b0);
    wcnt = 0;
    fcnt = 0;
    popcnt = 0;
    vexp = 1'b0;
    prev_gray = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(posedge clk);
      #1;
      wseen = wcnt;
      if (wcnt < 40 && (wcnt - fcnt) < 16 && $urandom_range(0, 1) == 1) begin
        mem[wcnt % 16] = dat(wcnt);
        wcnt++;
        bus.i_wptr_gray_sync = bin2gray(5'(wcnt));
      end
      bus.i_rd_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      eexp = (fcnt == wseen);
      lvl  = wseen - fcnt + int'(vexp);
      fexp = !eexp && (!vexp || bus.i_rd_ready);
      check_eq("t5_empty", bus.o_empty, eexp);
      check_eq("t5_level", bus.o_level, lvl);
      check_eq("t5_ae", bus.o_almost_empty, lvl <= 2);
      check_eq("t5_valid", bus.o_rd_valid, vexp);
      check_eq("t5_rd_en", bus.o_mem_rd_en, fexp);
      if (fexp) begin
        check_eq("t5_raddr", bus.o_mem_raddr, fcnt % 16);
        fcnt++;
      end
      if (vexp && bus.i_rd_ready) begin
        check_eq("t5_data", rdata, dat(popcnt));
        popcnt++;
      end
      vexp = fexp | (vexp & ~bus.i_rd_ready);
      check_eq("t5_gray_step", $countones(bus.o_rptr_gray ^ prev_gray) <= 1, 1);
      prev_gray = bus.o_rptr_gray;
      if (popcnt == 40) break;
    end
    check_eq("t5_pop_count", popcnt, 40);
    // 5-bit pointer: 40 wraps to 8.
    check_eq("t5_rgray", bus.o_rptr_gray, bin2gray(5'd8));

    // 6: asynchronous reset in the middle of a burst.
    do_reset(5'd0, 1'b1);
    bus.i_wptr_gray_sync = bin2gray(5'd16);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("t6_busy", bus.o_rd_valid, 1);
    #1;
    rst = 1'b1;
    #1;
    check_eq("t6_valid", bus.o_rd_valid, 0);
    check_eq("t6_empty", bus.o_empty, 1);
    check_eq("t6_rgray", bus.o_rptr_gray, 0);
    check_eq("t6_level", bus.o_level, 0);
    check_eq("t6_ae", bus.o_almost_empty, 1);
    check_eq("t6_rd_en", bus.o_mem_rd_en, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("t6_resume_level", bus.o_level, 16);
    check_eq("t6_resume_rd_en", bus.o_mem_rd_en, 1);
    check_eq("t6_resume_raddr", bus.o_mem_raddr, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
